// File: rtl/pmem_read_arbiter.sv
// Physical-memory port arbiter between the L2 cache (read/writeback) and the prefetcher.
// Default: L2 priority with a prefetcher starvation counter; PMEM_ARB_ROUND_ROBIN_EN selects round-robin.
module pmem_read_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned PF_MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              pf_read,
    input  logic [ADDR_W-1:0] pf_address,
    output logic              pf_resp,
    output logic [LINE_W-1:0] pf_rdata,

    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [ADDR_W-1:0] l2_address,
    input  logic [LINE_W-1:0] l2_wdata,
    output logic              l2_resp,
    output logic [LINE_W-1:0] l2_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StL2Xfer = 2'd1,
        StPfXfer = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic                rd_q;
    logic                wr_q;
    logic                l2_req;
    logic                grant_pf;

    assign l2_req = l2_read | l2_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    // 1 = prefetcher won the most recent grant; reset to PF so L2 wins the first tie.
    logic last_grant_pf_q;

    assign grant_pf = pf_read && (!l2_req || !last_grant_pf_q);
`else
    logic [3:0] wait_cnt_q;

    assign grant_pf = pf_read && (!l2_req || (wait_cnt_q == 4'(PF_MAX_WAIT)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            last_grant_pf_q <= 1'b1;
`else
            wait_cnt_q      <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_pf) begin
                        state_q <= StPfXfer;
                        addr_q  <= pf_address;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                        last_grant_pf_q <= 1'b1;
`else
                        wait_cnt_q      <= '0;
`endif
                    end else if (l2_req) begin
                        state_q <= StL2Xfer;
                        addr_q  <= l2_address;
                        // An illegal read+write request is performed as the write.
                        rd_q    <= ~l2_write;
                        wr_q    <= l2_write;
                        if (l2_write) begin
                            wdata_q <= l2_wdata;
                        end
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                        last_grant_pf_q <= 1'b0;
`else
                        if (pf_read && (wait_cnt_q != 4'(PF_MAX_WAIT))) begin
                            wait_cnt_q <= wait_cnt_q + 4'd1;
                        end
`endif
                    end
                end
                StL2Xfer, StPfXfer: begin
                    if (pmem_resp) begin
                        state_q <= StIdle;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Responses are a same-cycle pass-through of the memory completion.
    assign pf_resp  = (state_q == StPfXfer) && pmem_resp;
    assign l2_resp  = (state_q == StL2Xfer) && pmem_resp;
    assign pf_rdata = pf_resp ? pmem_rdata : '0;
    assign l2_rdata = l2_resp ? pmem_rdata : '0;

`ifndef SYNTHESIS
    l2_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(l2_read && l2_write))
        else $error("l2_read and l2_write asserted together");
`endif

endmodule

// File: tb/tb_pmem_read_arbiter.sv
// Scoreboard bench for pmem_read_arbiter: stimulus pushes expected grants/responses,
// a monitor pops and compares whenever a transaction starts or a response pulses.
module tb_pmem_read_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pf_read;
    logic [15:0]  pf_address;
    logic         pf_resp;
    logic [127:0] pf_rdata;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic         l2_resp;
    logic [127:0] l2_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    pmem_read_arbiter #(
        .ADDR_W      (16),
        .LINE_W      (128),
        .PF_MAX_WAIT (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pf_read      (pf_read),
        .pf_address   (pf_address),
        .pf_resp      (pf_resp),
        .pf_rdata     (pf_rdata),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_resp      (l2_resp),
        .l2_rdata     (l2_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } grant_t;

    typedef struct packed {
        logic         pf;
        logic [127:0] data;
    } resp_t;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];
    int     checks = 0;
    int     errors = 0;
    bit     mem_en = 1'b1;
    int     mem_lat = 4;

    function automatic logic [127:0] mem_data(input logic [15:0] a);
        if (a == 16'h1230) return {16{8'hA5}};
        return {8{a ^ 16'h5A5A}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_resp(input bit pf, input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            #2;
            if (pf ? pf_resp : l2_resp) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: got no resp expected resp within 64 cycles", name);
    endtask

    task automatic do_pf(input logic [15:0] a);
        pf_read    = 1'b1;
        pf_address = a;
        wait_resp(1'b1, "pf_resp_timeout");
        pf_read    = 1'b0;
    endtask

    // Back-to-back L2 requests with the request line held high between them.
    task automatic do_l2_seq(input logic wr, input logic [15:0] a0, input int n);
        for (int k = 0; k < n; k++) begin
            l2_read    = !wr;
            l2_write   = wr;
            l2_address = a0 + 16'(k);
            wait_resp(1'b0, "l2_resp_timeout");
        end
        l2_read  = 1'b0;
        l2_write = 1'b0;
    endtask

    function automatic grant_t rd_g(input logic [15:0] a);
        return '{wr: 1'b0, addr: a, wdata: '0};
    endfunction

    function automatic resp_t rsp(input logic pf, input logic [15:0] a);
        return '{pf: pf, data: mem_data(a)};
    endfunction

    // Memory model: completes each strobe after mem_lat sampled cycles.
    initial begin
        int lat_cnt;
        lat_cnt    = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!mem_en) continue;
            if (rst_n && (pmem_read || pmem_write) && !pmem_resp) begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_data(pmem_address);
                    lat_cnt    = 0;
                end
            end else begin
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
                lat_cnt    = 0;
            end
        end
    end

    // Monitor: compares transaction starts and response pulses against the queues.
    initial begin
        bit prev_strobe;
        bit strobe;
        grant_t g;
        resp_t  r;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_strobe = 1'b0;
                continue;
            end
            strobe = pmem_read || pmem_write;
            chk("rd_wr_exclusive", 128'(pmem_read && pmem_write), 128'd0);
            chk("resp_exclusive", 128'(pf_resp && l2_resp), 128'd0);
            if (strobe && !prev_strobe) begin
                if (exp_grant.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got addr %h expected no transaction",
                             pmem_address);
                end else begin
                    g = exp_grant.pop_front();
                    chk("grant_addr", 128'(pmem_address), 128'(g.addr));
                    chk("grant_write", 128'(pmem_write), 128'(g.wr));
                    chk("grant_read", 128'(pmem_read), 128'(!g.wr));
                    if (g.wr) chk("grant_wdata", pmem_wdata, g.wdata);
                end
            end
            if (pf_resp || l2_resp) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got pf=%0b l2=%0b expected none",
                             pf_resp, l2_resp);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_pf", 128'(pf_resp), 128'(r.pf));
                    chk("resp_l2", 128'(l2_resp), 128'(!r.pf));
                    chk("resp_rdata", r.pf ? pf_rdata : l2_rdata, r.data);
                end
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        pf_read    = 1'b0;
        pf_address = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        #1;
        chk("reset_pmem_read", 128'(pmem_read), 128'd0);
        chk("reset_pmem_write", 128'(pmem_write), 128'd0);
        chk("reset_pmem_address", 128'(pmem_address), 128'd0);
        chk("reset_resp", 128'({pf_resp, l2_resp}), 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;

        // 1: lone prefetch, strobe in the cycle after the request.
        exp_grant.push_back(rd_g(16'h1230));
        exp_resp.push_back('{pf: 1'b1, data: {16{8'hA5}}});
        fork
            do_pf(16'h1230);
            begin
                @(negedge clk);
                #2;
                chk("t1_strobe_latency", 128'(pmem_read), 128'd1);
                chk("t1_addr", 128'(pmem_address), 128'h1230);
            end
        join
        @(negedge clk);
        #2;

        // 2: simultaneous requests, L2 first.
        exp_grant.push_back(rd_g(16'h0080));
        exp_grant.push_back(rd_g(16'h0040));
        exp_resp.push_back(rsp(1'b0, 16'h0080));
        exp_resp.push_back(rsp(1'b1, 16'h0040));
        fork
            do_pf(16'h0040);
            do_l2_seq(1'b0, 16'h0080, 1);
        join
        @(negedge clk);
        #2;

        // 3 / 6: continuous L2 with prefetch held.
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        exp_grant.push_back(rd_g(16'h0200));
        exp_grant.push_back(rd_g(16'h0100));
        exp_grant.push_back(rd_g(16'h0201));
        exp_resp.push_back(rsp(1'b0, 16'h0200));
        exp_resp.push_back(rsp(1'b1, 16'h0100));
        exp_resp.push_back(rsp(1'b0, 16'h0201));
        fork
            do_pf(16'h0100);
            do_l2_seq(1'b0, 16'h0200, 2);
        join
`else
        for (int k = 0; k < 3; k++) exp_grant.push_back(rd_g(16'h0200 + 16'(k)));
        exp_grant.push_back(rd_g(16'h0100));
        exp_grant.push_back(rd_g(16'h0203));
        for (int k = 0; k < 3; k++) exp_resp.push_back(rsp(1'b0, 16'h0200 + 16'(k)));
        exp_resp.push_back(rsp(1'b1, 16'h0100));
        exp_resp.push_back(rsp(1'b0, 16'h0203));
        fork
            do_pf(16'h0100);
            do_l2_seq(1'b0, 16'h0200, 4);
        join
`endif
        @(negedge clk);
        #2;

        // 3b: counter cleared (default) / last grant was L2 (round-robin).
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        exp_grant.push_back(rd_g(16'h0400));
        exp_grant.push_back(rd_g(16'h0500));
        exp_resp.push_back(rsp(1'b1, 16'h0400));
        exp_resp.push_back(rsp(1'b0, 16'h0500));
`else
        exp_grant.push_back(rd_g(16'h0500));
        exp_grant.push_back(rd_g(16'h0400));
        exp_resp.push_back(rsp(1'b0, 16'h0500));
        exp_resp.push_back(rsp(1'b1, 16'h0400));
`endif
        fork
            do_pf(16'h0400);
            do_l2_seq(1'b0, 16'h0500, 1);
        join
        @(negedge clk);
        #2;

        // 4: writeback.
        l2_wdata = {16{8'h11}};
        exp_grant.push_back('{wr: 1'b1, addr: 16'h2000, wdata: {16{8'h11}}});
        exp_resp.push_back(rsp(1'b0, 16'h2000));
        do_l2_seq(1'b1, 16'h2000, 1);
        l2_wdata = '0;
        @(negedge clk);
        #2;

        // 5: reset two cycles before completion abandons the transfer.
        exp_grant.push_back(rd_g(16'h3000));
        pf_read    = 1'b1;
        pf_address = 16'h3000;
        repeat (2) begin
            @(negedge clk);
            #2;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pmem_read", 128'(pmem_read), 128'd0);
        chk("t5_rst_pmem_address", 128'(pmem_address), 128'd0);
        chk("t5_rst_pmem_wdata", pmem_wdata, 128'd0);
        chk("t5_rst_pf_resp", 128'(pf_resp), 128'd0);
        chk("t5_rst_pf_rdata", pf_rdata, 128'd0);
        pf_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("t5_idle_after_release", 128'({pmem_read, pmem_write}), 128'd0);
        mem_en = 1'b0;
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = '1;
        #2;
        chk("t5_stray_resp", 128'({pf_resp, l2_resp}), 128'd0);
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        mem_en     = 1'b1;

        for (int i = 0; i < 32 && (exp_grant.size() != 0 || exp_resp.size() != 0); i++) begin
            @(negedge clk);
        end
        #3;
        chk("grant_queue_drained", 128'(exp_grant.size()), 128'd0);
        chk("resp_queue_drained", 128'(exp_resp.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
